cam_lru_cache: RTL and testbench

Fully-associative tag-matched cache built on a CAM lookup array, with a registered lookup response, fill-allocate, tag invalidate, sequenced flush and a replacement policy. It replaces the single-cycle combinational CAM in the cache datapath. Memory-side logic drives `fill` and `invalidate`. The requester drives `lookup` and consumes the one-cycle-later response.

---
 rtl/cam_lru_cache.sv | 192 +++++++++++++++++++
 tb/tb_cam_lru_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_lru_cache.sv
// rtl/cam_lru_cache.sv - fully-associative CAM cache with registered lookup, fill, invalidate, flush; CAM_LRU_EN selects true LRU over round-robin
module cam_lru_cache #(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS)-1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup,
   input  logic [TAG_SZ-1:0]   check_tag,
   input  logic                fill,
   input  logic [TAG_SZ-1:0]   new_tag,
   input  logic [BITS-1:0]     wdata,
   input  logic                invalidate,
   input  logic [TAG_SZ-1:0]   inv_tag,
   input  logic                flush,
   output logic                resp_valid,
   output logic                found_it,
   output logic [BITS-1:0]     data,
   output logic [ADDR_LEFT:0]  match_addr,
   output logic                busy,
   output logic                full
);

   localparam logic [0:0]         ST_IDLE  = 1'b0;
   localparam logic [0:0]         ST_FLUSH = 1'b1;
   localparam logic [ADDR_LEFT:0] LAST_IDX = '1;

   logic [BITS-1:0]    data_mem [WORDS];
   logic [TAG_SZ-1:0]  tag_mem  [WORDS];
   logic [WORDS-1:0]   val_mem;
   logic [0:0]         state;
   logic [ADDR_LEFT:0] counter;

   logic               lk_hit;
   logic [ADDR_LEFT:0] lk_idx;
   logic               fl_hit;
   logic [ADDR_LEFT:0] fl_idx;
   logic               has_free;
   logic [ADDR_LEFT:0] free_idx;
   logic [WORDS-1:0]   inv_vec;
   logic [ADDR_LEFT:0] victim;
   logic [ADDR_LEFT:0] fill_idx;
   logic               lk_ok;
   logic               do_inv;
   logic               do_fill;

   assign busy = (state == ST_FLUSH);
   assign full = &val_mem;

   // Tag compare against every valid entry; lowest index wins on multiple matches
   always_comb begin
      lk_hit   = 1'b0;
      lk_idx   = '0;
      fl_hit   = 1'b0;
      fl_idx   = '0;
      has_free = 1'b0;
      free_idx = '0;
      inv_vec  = '0;
      for (int i = WORDS-1; i >= 0; i--) begin
         if (val_mem[i] && tag_mem[i] == check_tag) begin
            lk_hit = 1'b1;
            lk_idx = i[ADDR_LEFT:0];
         end
         if (val_mem[i] && tag_mem[i] == new_tag) begin
            fl_hit = 1'b1;
            fl_idx = i[ADDR_LEFT:0];
         end
         if (!val_mem[i]) begin
            has_free = 1'b1;
            free_idx = i[ADDR_LEFT:0];
         end
         inv_vec[i] = val_mem[i] && (tag_mem[i] == inv_tag);
      end
   end

   // Flush start and an active flush outrank invalidate, which outranks fill
   assign do_inv   = invalidate && (state == ST_IDLE) && !flush;
   assign do_fill  = fill && (state == ST_IDLE) && !flush && !invalidate;
   assign lk_ok    = lookup && lk_hit && (state == ST_IDLE);
   assign fill_idx = fl_hit ? fl_idx : (has_free ? free_idx : victim);

`ifdef CAM_LRU_EN
   logic [ADDR_LEFT:0] age     [WORDS];
   logic [ADDR_LEFT:0] age_a   [WORDS];
   logic [ADDR_LEFT:0] age_nxt [WORDS];

   // Victim is the oldest entry, the one whose age is WORDS-1
   always_comb begin
      victim = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (age[i] == LAST_IDX) victim = i[ADDR_LEFT:0];
      end
   end

   // Lookup hit touches first, then a fill touches on top of that result
   always_comb begin
      for (int i = 0; i < WORDS; i++) begin
         age_a[i] = age[i];
         if (lk_ok) begin
            if (i[ADDR_LEFT:0] == lk_idx) age_a[i] = '0;
            else if (age[i] < age[lk_idx]) age_a[i] = age[i] + 1'b1;
         end
      end
      for (int i = 0; i < WORDS; i++) begin
         age_nxt[i] = age_a[i];
         if (do_fill) begin
            if (i[ADDR_LEFT:0] == fill_idx) age_nxt[i] = '0;
            else if (age_a[i] < age_a[fill_idx]) age_nxt[i] = age_a[i] + 1'b1;
         end
      end
   end

   // Age registers; reset leaves entry i with age i
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) age[i] <= i[ADDR_LEFT:0];
      end else begin
         for (int i = 0; i < WORDS; i++) age[i] <= age_nxt[i];
      end
   end
`else
   logic [ADDR_LEFT:0] rr;
   logic               do_replace;

   assign victim     = rr;
   assign do_replace = do_fill && !fl_hit && !has_free;

   // Round-robin pointer advances only when a fill evicts a valid entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr <= '0;
      else if (do_replace) rr <= rr + 1'b1;
   end
`endif

   // Data and tag arrays carry no reset; a tag hit keeps its tag and takes new data
   always_ff @(posedge clk) begin
      if (do_fill) begin
         data_mem[fill_idx] <= wdata;
         if (!fl_hit) tag_mem[fill_idx] <= new_tag;
      end
   end

   // Valid bits and the flush sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_mem <= '0;
         state   <= ST_IDLE;
         counter <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (flush) begin
                  state   <= ST_FLUSH;
                  counter <= '0;
               end else if (do_inv) begin
                  val_mem <= val_mem & ~inv_vec;
               end else if (do_fill) begin
                  val_mem[fill_idx] <= 1'b1;
               end
            end
            ST_FLUSH: begin
               val_mem[counter] <= 1'b0;
               if (counter == LAST_IDX) begin
                  state   <= ST_IDLE;
                  counter <= '0;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered lookup response; misses and idle cycles report zeros
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         found_it   <= 1'b0;
         data       <= '0;
         match_addr <= '0;
      end else begin
         resp_valid <= lookup;
         found_it   <= lk_ok;
         data       <= lk_ok ? data_mem[lk_idx] : '0;
         match_addr <= lk_ok ? lk_idx : '0;
      end
   end

endmodule

// File: tb/tb_cam_lru_cache.sv
// tb/tb_cam_lru_cache.sv - directed scoreboard bench for cam_lru_cache
module tb_cam_lru_cache;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lookup = 1'b0;
   logic [7:0] check_tag = '0;
   logic       fill = 1'b0;
   logic [7:0] new_tag = '0;
   logic [7:0] wdata = '0;
   logic       invalidate = 1'b0;
   logic [7:0] inv_tag = '0;
   logic       flush = 1'b0;
   logic       resp_valid;
   logic       found_it;
   logic [7:0] data;
   logic [2:0] match_addr;
   logic       busy;
   logic       full;

   typedef struct {
      logic       f;
      logic [7:0] d;
      logic [2:0] a;
   } exp_t;

   exp_t  exp_q [$];
   string tag_q [$];
   int    n_cmp = 0;
   int    n_err = 0;

   cam_lru_cache #(.WORDS(8), .BITS(8), .TAG_SZ(8)) dut (
      .clk(clk), .rst(rst), .lookup(lookup), .check_tag(check_tag),
      .fill(fill), .new_tag(new_tag), .wdata(wdata),
      .invalidate(invalidate), .inv_tag(inv_tag), .flush(flush),
      .resp_valid(resp_valid), .found_it(found_it), .data(data),
      .match_addr(match_addr), .busy(busy), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req_lookup(input string tag, input logic [7:0] t,
                             input logic f, input logic [7:0] d, input logic [2:0] a);
      exp_t e;
      e.f = f; e.d = d; e.a = a;
      lookup = 1'b1;
      check_tag = t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic req_fill(input logic [7:0] t, input logic [7:0] d);
      fill = 1'b1;
      new_tag = t;
      wdata = d;
   endtask

   // One clock: compare the response of this cycle's lookup, then drop all requests
   task automatic tick();
      exp_t  e;
      string tg;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         tg = tag_q.pop_front();
         chk({tg, "_rv"}, resp_valid, 1);
         chk({tg, "_hit"}, found_it, e.f);
         chk({tg, "_data"}, data, e.d);
         chk({tg, "_addr"}, match_addr, e.a);
      end else begin
         chk("idle_rv", resp_valid, 0);
         chk("idle_data", data, 0);
      end
      lookup = 1'b0;
      fill = 1'b0;
      invalidate = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic fill_eight();
      for (int i = 0; i < 8; i++) begin
         req_fill(8'h10 + 8'(i), 8'h80 + 8'(i));
         tick();
      end
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_rv", resp_valid, 0);
      chk("rst_hit", found_it, 0);
      chk("rst_data", data, 0);
      chk("rst_addr", match_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic fill then hit / miss
      req_fill(8'h11, 8'hA5); tick();
      req_lookup("lk11", 8'h11, 1, 8'hA5, 0); tick();
      req_lookup("lk22", 8'h22, 0, 8'h00, 0); tick();

      // Same-tag fill updates in place
      req_fill(8'h11, 8'h3C); tick();
      req_lookup("upd11", 8'h11, 1, 8'h3C, 0); tick();
      chk("upd_full", full, 0);
      req_fill(8'h12, 8'h77); tick();
      req_lookup("upd12", 8'h12, 1, 8'h77, 1); tick();

      // Fill to full, then replacement
      do_reset();
      fill_eight();
      chk("full8", full, 1);
      for (int i = 0; i < 8; i++) begin
         req_lookup("lk8", 8'h10 + 8'(i), 1, 8'h80 + 8'(i), 3'(i));
         tick();
      end
`ifdef CAM_LRU_EN
      req_lookup("lru_touch", 8'h10, 1, 8'h80, 0); tick();
      req_fill(8'h20, 8'hC0); tick();
      req_lookup("lru_new20", 8'h20, 1, 8'hC0, 1); tick();
      req_lookup("lru_gone11", 8'h11, 0, 8'h00, 0); tick();
      req_lookup("lru_keep10", 8'h10, 1, 8'h80, 0); tick();
      req_fill(8'h21, 8'hC1); tick();
      req_lookup("lru_new21", 8'h21, 1, 8'hC1, 2); tick();
      req_lookup("lru_gone12", 8'h12, 0, 8'h00, 0); tick();
`else
      req_fill(8'h20, 8'hC0); tick();
      req_lookup("rr_new20", 8'h20, 1, 8'hC0, 0); tick();
      req_lookup("rr_gone10", 8'h10, 0, 8'h00, 0); tick();
      req_fill(8'h21, 8'hC1); tick();
      req_lookup("rr_new21", 8'h21, 1, 8'hC1, 1); tick();
      req_lookup("rr_gone11", 8'h11, 0, 8'h00, 0); tick();
`endif
      chk("repl_full", full, 1);

      // Invalidate beats fill in the same cycle
      do_reset();
      fill_eight();
      invalidate = 1'b1;
      inv_tag = 8'h13;
      req_fill(8'h20, 8'hD0);
      tick();
      chk("inv_full", full, 0);
      req_lookup("inv13", 8'h13, 0, 8'h00, 0); tick();
      req_lookup("drop20", 8'h20, 0, 8'h00, 0); tick();
      req_fill(8'h20, 8'hD0); tick();
      req_lookup("refill20", 8'h20, 1, 8'hD0, 3); tick();
      chk("refill_full", full, 1);

      // Full flush with lookups and an ignored fill while busy
      do_reset();
      fill_eight();
      flush = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) begin
         chk("fl_busy", busy, 1);
         chk("fl_full", full, (j == 0) ? 1 : 0);
         req_lookup("fl_lk", 8'h10, 0, 8'h00, 0);
         if (j == 4) req_fill(8'h30, 8'hEE);
         tick();
      end
      chk("fl_done_busy", busy, 0);
      chk("fl_done_full", full, 0);
      for (int i = 0; i < 8; i++) begin
         req_lookup("post_fl", 8'h10 + 8'(i), 0, 8'h00, 0);
         tick();
      end
      req_lookup("post_fl30", 8'h30, 0, 8'h00, 0); tick();

      // Reset in the middle of a flush
      do_reset();
      fill_eight();
      flush = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_full", full, 0);
      chk("mid_rv", resp_valid, 0);
      tick();
      rst = 1'b0;
      req_fill(8'h40, 8'hE0); tick();
      req_lookup("mid40", 8'h40, 1, 8'hE0, 0); tick();
      req_lookup("mid17", 8'h17, 0, 8'h00, 0); tick();
      req_lookup("mid15", 8'h15, 0, 8'h00, 0); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
